// File: rtl/audio_pkg.sv
// Shared types and default widths for the analog-sound sample path.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_VOICES = 4;
   localparam int DEF_ADDR_W     = 25;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/sample_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = $clog2(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0] pend,
   input  logic [IDX_W-1:0]      rr_ptr,
   output logic [IDX_W-1:0]      grant,
   output logic                  any_valid
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      sum       = '0;
      idx       = '0;
      // Scan from the farthest candidate back to rr_ptr so the nearest set bit wins.
      for (int k = NUM_VOICES - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(NUM_VOICES))
            sum = sum - (IDX_W + 1)'(NUM_VOICES);
         idx = sum[IDX_W-1:0];
         if (pend[idx]) begin
            grant     = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sample_fetch_arbiter.sv
// Shares the SDRAM sample-read port among the sound voices: latches per-voice
// requests, grants round-robin, runs the req/ack handshake and returns data.
module sample_fetch_arbiter
   import audio_pkg::*;
#(
   parameter int NUM_VOICES = DEF_NUM_VOICES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_VOICES-1:0]        voice_req,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
   output logic [NUM_VOICES*DATA_W-1:0] voice_data,
   output logic [NUM_VOICES-1:0]        voice_valid,
   output logic [NUM_VOICES-1:0]        overrun,
   output logic                         timeout_err,
   input  logic                         err_clr,
   output logic                         sdram_req,
   output logic [ADDR_W-1:0]            sdram_addr,
   input  logic                         sdram_ack,
   input  logic [DATA_W-1:0]            sdram_data
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t             state_q, state_d;
   logic [NUM_VOICES-1:0]  pend_q;
   logic [ADDR_W-1:0]      addr_q [NUM_VOICES];
   logic [IDX_W-1:0]       rr_ptr_q, grant_q, pick;
   logic [CNT_W-1:0]       wait_cnt_q;
   logic                   any_pend, take, ack_hit, expire;
   logic [NUM_VOICES-1:0]  take_vec, ovr_set;

   rr_pick #(
      .NUM_VOICES(NUM_VOICES),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .pend     (pend_q),
      .rr_ptr   (rr_ptr_q),
      .grant    (pick),
      .any_valid(any_pend)
   );

   // The fetch is abandoned on its TIMEOUT-th WAIT cycle; an ack in that same cycle still wins.
   always_comb begin
      take     = (state_q == IDLE) && any_pend;
      ack_hit  = (state_q == WAIT) && sdram_ack;
      expire   = (state_q == WAIT) && !sdram_ack && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
      take_vec = '0;
      if (take)
         take_vec[pick] = 1'b1;
      ovr_set  = voice_req & pend_q & ~take_vec;
      state_d  = state_q;
      case (state_q)
         IDLE:    if (any_pend) state_d = WAIT;
         WAIT:    if (ack_hit || expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q      <= '0;
         // NOTE: the address latches are a small register array, cleared so the first fetch is deterministic.
         for (int i = 0; i < NUM_VOICES; i++)
            addr_q[i] <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         wait_cnt_q  <= '0;
         sdram_req   <= 1'b0;
         sdram_addr  <= '0;
         voice_data  <= '0;
         voice_valid <= '0;
         overrun     <= '0;
         timeout_err <= 1'b0;
      end else begin
         voice_valid <= '0;
         overrun     <= (overrun & ~{NUM_VOICES{err_clr}}) | ovr_set;
         timeout_err <= (timeout_err & ~err_clr) | expire;

         // A request in the grant cycle wins over the clear, so it stays pending.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_req[i]) begin
               pend_q[i] <= 1'b1;
               addr_q[i] <= voice_addr[i*ADDR_W +: ADDR_W];
            end else if (take_vec[i]) begin
               pend_q[i] <= 1'b0;
            end
         end

         if (take) begin
            grant_q    <= pick;
            sdram_req  <= 1'b1;
            sdram_addr <= addr_q[pick];
            wait_cnt_q <= '0;
         end

         if (state_q == WAIT)
            wait_cnt_q <= wait_cnt_q + 1'b1;

         if (ack_hit) begin
            voice_data[grant_q*DATA_W +: DATA_W] <= sdram_data;
            voice_valid[grant_q]                 <= 1'b1;
         end

         if (ack_hit || expire) begin
            sdram_req <= 1'b0;
            rr_ptr_q  <= (grant_q == IDX_W'(NUM_VOICES - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sample_fetch_arbiter.sv
// Self-checking bench for sample_fetch_arbiter: table-driven round-robin vectors,
// hand-written corner sequences and randomized traffic against a transaction-level model.
module tb_sample_fetch_arbiter;

   localparam int NV      = 4;
   localparam int AW      = 25;
   localparam int DW      = 16;
   localparam int TIMEOUT = 255;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NV-1:0]      voice_req = '0;
   logic [NV*AW-1:0]   voice_addr = '0;
   logic [NV*DW-1:0]   voice_data;
   logic [NV-1:0]      voice_valid;
   logic [NV-1:0]      overrun;
   logic               timeout_err;
   logic               err_clr = 1'b0;
   logic               sdram_req;
   logic [AW-1:0]      sdram_addr;
   logic               sdram_ack = 1'b0;
   logic [DW-1:0]      sdram_data = '0;

   sample_fetch_arbiter #(
      .NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .voice_req  (voice_req),
      .voice_addr (voice_addr),
      .voice_data (voice_data),
      .voice_valid(voice_valid),
      .overrun    (overrun),
      .timeout_err(timeout_err),
      .err_clr    (err_clr),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .sdram_data (sdram_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  v;
      logic [15:0] d;
   } exp_t;

   typedef struct packed {
      logic            pre_en;
      logic [1:0]      pre;
      logic [3:0]      mask;
      logic [2:0]      n;
      logic [3:0][1:0] ord;
   } rr_vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Responder and model state.
   int             ack_lat, cur_lat, req_cnt;
   bit             rnd_lat, use_fixed, stray_ack, req_prev, addr_stable;
   logic [15:0]    resp_data;
   logic [AW-1:0]  rise_addr;
   logic [NV-1:0]  model_pend, model_ovr;
   logic [AW-1:0]  model_addr [NV];
   int             model_ptr;
   logic [NV-1:0][DW-1:0] model_data;
   exp_t           exp_q [$];
   int             seen_q [$];
   logic [AW-1:0]  rise_log [$];
   rr_vec_t        tbl [7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_data(input logic [AW-1:0] a);
      return use_fixed ? resp_data : (a[15:0] ^ 16'h5A3C);
   endfunction

   task automatic set_addr(input int v, input logic [AW-1:0] a);
      voice_addr[v*AW +: AW] = a;
   endtask

   task automatic model_reset();
      model_pend = '0;
      model_ovr  = '0;
      model_ptr  = 0;
      model_data = '0;
      for (int v = 0; v < NV; v++) model_addr[v] = '0;
      exp_q.delete();
      seen_q.delete();
      rise_log.delete();
      req_prev  = 1'b0;
      req_cnt   = 0;
      cur_lat   = 0;
      stray_ack = 1'b0;
      rnd_lat   = 1'b0;
   endtask

   // Grant decision seen at a sdram_req rise: first pending voice at or after the pointer.
   task automatic model_decide(input bit will_ack);
      int v;
      v = -1;
      rise_log.push_back(sdram_addr);
      if (model_pend == '0) begin
         check("req_without_pending", sdram_req, 1'b0);
      end else begin
         for (int k = 0; k < NV; k++)
            if (v < 0 && model_pend[(model_ptr + k) % NV]) v = (model_ptr + k) % NV;
         check("grant_addr", sdram_addr, model_addr[v]);
         model_pend[v] = 1'b0;
         model_ptr     = (v + 1) % NV;
         if (will_ack) exp_q.push_back({2'(v), exp_data(model_addr[v])});
      end
   endtask

   // One clock: responder, output checks, then fold this cycle's requests into the model.
   task automatic step();
      logic [NV-1:0]    cur_req;
      logic [NV*AW-1:0] cur_addr;
      logic             cur_clr;
      logic [NV-1:0]    ovr_set;
      exp_t             e;
      cur_req  = voice_req;
      cur_addr = voice_addr;
      cur_clr  = err_clr;
      @(posedge clk);
      #1;
      if (sdram_req) begin
         if (!req_prev) begin
            req_cnt     = 0;
            rise_addr   = sdram_addr;
            addr_stable = 1'b1;
            cur_lat     = rnd_lat ? int'($urandom_range(1, 6)) : ack_lat;
            model_decide(cur_lat >= 0);
         end
         req_cnt++;
         if (sdram_addr !== rise_addr) addr_stable = 1'b0;
         sdram_ack  = (cur_lat >= 0) && (req_cnt == cur_lat + 1);
         sdram_data = sdram_ack ? exp_data(sdram_addr) : 16'($urandom);
      end else begin
         if (req_prev) check("addr_stable", addr_stable, 1'b1);
         sdram_ack  = stray_ack;
         sdram_data = 16'($urandom);
      end
      req_prev = sdram_req;

      if (voice_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", voice_valid, '0);
         end else begin
            e = exp_q.pop_front();
            check("valid_voice", voice_valid, 4'b0001 << e.v);
            model_data[e.v] = e.d;
            seen_q.push_back(int'(e.v));
         end
      end
      check("voice_data", voice_data, model_data);

      ovr_set = '0;
      for (int v = 0; v < NV; v++) begin
         if (cur_req[v]) begin
            if (model_pend[v]) ovr_set[v] = 1'b1;
            model_pend[v] = 1'b1;
            model_addr[v] = cur_addr[v*AW +: AW];
         end
      end
      model_ovr = (model_ovr & ~{NV{cur_clr}}) | ovr_set;
      check("overrun", overrun, model_ovr);
      voice_req = '0;
      err_clr   = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || model_pend != '0 || sdram_req) && n < 3000) begin
         step();
         n++;
      end
      check("idle_reached", n < 3000, 1'b1);
      repeat (3) step();
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      voice_req = '0;
      err_clr   = 1'b0;
      sdram_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int n;
      //             pre_en pre   mask     n     ord[3..0]
      tbl[0] = '{1'b0, 2'd0, 4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
      tbl[1] = '{1'b1, 2'd1, 4'b1111, 3'd4, {2'd1, 2'd0, 2'd3, 2'd2}};
      tbl[2] = '{1'b1, 2'd3, 4'b1010, 3'd2, {2'd0, 2'd0, 2'd3, 2'd1}};
      tbl[3] = '{1'b1, 2'd2, 4'b0011, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};
      tbl[4] = '{1'b1, 2'd0, 4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[5] = '{1'b1, 2'd3, 4'b1000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[6] = '{1'b1, 2'd1, 4'b0101, 3'd2, {2'd0, 2'd0, 2'd0, 2'd2}};
      use_fixed = 1'b0;
      resp_data = '0;
      ack_lat   = 3;

      // Reset state and single-request latency.
      apply_reset();
      check("reset_outputs", {sdram_req, sdram_addr, voice_valid, voice_data, overrun, timeout_err}, '0);
      use_fixed = 1'b1;
      resp_data = 16'hBEEF;
      ack_lat   = 5;
      set_addr(2, 25'h0001234);
      voice_req = 4'b0100;
      step();
      check("single_req_c1", sdram_req, 1'b0);
      step();
      check("single_req_c2", sdram_req, 1'b1);
      check("single_addr", sdram_addr, 25'h0001234);
      repeat (6) step();
      check("single_valid", voice_valid, 4'b0100);
      check("single_data", voice_data[2*DW +: DW], 16'hBEEF);
      check("single_req_dropped", sdram_req, 1'b0);
      step();
      check("single_valid_once", voice_valid, 4'b0000);
      wait_idle();
      use_fixed = 1'b0;

      // Round-robin order vectors.
      for (int r = 0; r < 7; r++) begin
         apply_reset();
         ack_lat = 3;
         if (tbl[r].pre_en) begin
            voice_req[tbl[r].pre] = 1'b1;
            set_addr(int'(tbl[r].pre), AW'($urandom));
            step();
            wait_idle();
         end
         seen_q.delete();
         for (int v = 0; v < NV; v++) set_addr(v, AW'($urandom));
         voice_req = tbl[r].mask;
         step();
         wait_idle();
         check("rr_count", seen_q.size(), tbl[r].n);
         for (int k = 0; k < int'(tbl[r].n) && k < seen_q.size(); k++)
            check("rr_order", seen_q[k], tbl[r].ord[k]);
      end

      // Fairness: voices 0 and 1 re-request as soon as their data returns.
      apply_reset();
      ack_lat = 2;
      set_addr(0, AW'($urandom));
      set_addr(1, AW'($urandom));
      voice_req = 4'b0011;
      step();
      n = 0;
      while (seen_q.size() < 20 && n < 500) begin
         for (int v = 0; v < 2; v++)
            if (voice_valid[v]) begin
               voice_req[v] = 1'b1;
               set_addr(v, AW'($urandom));
            end
         step();
         n++;
      end
      check("fair_bound", n < 500, 1'b1);
      for (int k = 0; k < 20 && k < seen_q.size(); k++) check("fair_alternate", seen_q[k], k % 2);
      wait_idle();

      // Overrun: address replacement, set-wins-over-clear, then clear.
      apply_reset();
      ack_lat = 10;
      set_addr(0, 25'h0000100);
      voice_req = 4'b0001;
      step();
      step();
      set_addr(1, 25'h000AAAA);
      voice_req = 4'b0010;
      step();
      set_addr(1, 25'h000BBBB);
      voice_req = 4'b0010;
      step();
      check("overrun_set", overrun[1], 1'b1);
      set_addr(1, 25'h000CCCC);
      voice_req = 4'b0010;
      err_clr   = 1'b1;
      step();
      check("overrun_set_wins", overrun[1], 1'b1);
      err_clr = 1'b1;
      step();
      check("overrun_cleared", overrun, 4'b0000);
      wait_idle();
      check("overrun_fetches", rise_log.size(), 2);
      if (rise_log.size() == 2) check("overrun_latest_addr", rise_log[1], 25'h000CCCC);

      // Request in the same cycle its pending bit is granted: pending again, no overrun.
      apply_reset();
      ack_lat = 3;
      set_addr(2, 25'h0012345);
      voice_req = 4'b0100;
      step();
      set_addr(2, 25'h0054321);
      voice_req = 4'b0100;
      step();
      check("grant_cycle_no_overrun", overrun, 4'b0000);
      wait_idle();
      check("grant_cycle_fetches", rise_log.size(), 2);
      if (rise_log.size() == 2) check("grant_cycle_second", rise_log[1], 25'h0054321);

      // Timeout: exactly TIMEOUT cycles of sdram_req, no valid, data kept, next voice served.
      apply_reset();
      use_fixed = 1'b1;
      resp_data = 16'hC0DE;
      ack_lat   = 3;
      set_addr(3, 25'h00ABCDE);
      voice_req = 4'b1000;
      step();
      wait_idle();
      ack_lat = -1;
      set_addr(3, 25'h0001111);
      voice_req = 4'b1000;
      step();
      step();
      set_addr(1, 25'h0002222);
      voice_req = 4'b0010;
      step();
      n = 0;
      while (sdram_req && n < 400) begin
         step();
         n++;
      end
      check("timeout_len", req_cnt, TIMEOUT);
      check("timeout_err_set", timeout_err, 1'b1);
      check("timeout_data_kept", voice_data[3*DW +: DW], 16'hC0DE);
      ack_lat = 3;
      seen_q.delete();
      wait_idle();
      check("timeout_next_served", seen_q.size(), 1);
      if (seen_q.size() == 1) check("timeout_next_voice", seen_q[0], 1);
      check("timeout_err_sticky", timeout_err, 1'b1);
      err_clr = 1'b1;
      step();
      check("timeout_err_cleared", timeout_err, 1'b0);

      // Ack on the last WAIT cycle beats the timeout.
      ack_lat = TIMEOUT - 1;
      set_addr(0, 25'h0003333);
      voice_req = 4'b0001;
      step();
      wait_idle();
      check("ack_wins_no_err", timeout_err, 1'b0);
      check("ack_wins_data", voice_data[0*DW +: DW], 16'hC0DE);
      use_fixed = 1'b0;

      // Async reset during WAIT.
      apply_reset();
      ack_lat = -1;
      set_addr(0, 25'h0000040);
      voice_req = 4'b0001;
      step();
      step();
      voice_req = 4'b0100;
      step();
      voice_req = 4'b0100;
      step();
      check("pre_reset_overrun", overrun, 4'b0100);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_req", sdram_req, 1'b0);
      check("async_rst_flags", {voice_valid, overrun, timeout_err}, '0);
      apply_reset();
      ack_lat = 3;
      set_addr(1, 25'h0007777);
      voice_req = 4'b0010;
      step();
      wait_idle();
      check("post_reset_served", seen_q.size(), 1);
      if (seen_q.size() == 1) check("post_reset_voice", seen_q[0], 1);

      // Randomized traffic with stray acks and occasional clears.
      apply_reset();
      rnd_lat = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         for (int v = 0; v < NV; v++)
            if ($urandom_range(0, 23) == 0) begin
               voice_req[v] = 1'b1;
               set_addr(v, AW'($urandom));
            end
         err_clr   = ($urandom_range(0, 39) == 0);
         stray_ack = ($urandom_range(0, 3) == 0);
         step();
      end
      stray_ack = 1'b0;
      wait_idle();
      check("random_no_timeout", timeout_err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
